// File: rtl/imem_pkg.sv
// Shared constants and the fixed program image for the instruction ROM.
// Entries past the end of the program are zero.
package imem_pkg;

    localparam int IMEM_DEPTH = 64;
    localparam int IMEM_AW    = 6;
    localparam int IMEM_DW    = 32;

    typedef logic [IMEM_DW-1:0] instr_t;

    localparam instr_t IMEM_INIT [0:IMEM_DEPTH-1] = '{
        32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
        32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
        32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
        32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
        32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
        32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
        32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
        32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
        32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
        32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
        32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
        32'h8b1003de, 32'hf81f83d9, 32'hb400001f, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
    };

endpackage

// File: rtl/imem_rom.sv
// Combinational instruction ROM: q follows addr with no clock involvement,
// and is forced to zero while the active-low reset is asserted.
module imem_rom
    import imem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IMEM_AW-1:0] addr,
    output logic [N-1:0]       q
);

    // Wide enough to hold a stored word zero-extended to N, or the full word when N < 32.
    localparam int WIDE_W = (N > IMEM_DW) ? N : IMEM_DW;

    instr_t            word;
    logic [WIDE_W-1:0] wideWord;

    // The clock only exists to match the rest of the datapath's port list.
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        word                  = IMEM_INIT[addr];
        wideWord              = '0;
        wideWord[IMEM_DW-1:0] = word;
        q                     = reset ? wideWord[N-1:0] : '0;
    end

endmodule

// File: tb/tb_imem_rom.sv
// Self-checking bench for imem_rom: expected words come from a local copy of
// the program image and flow through a scoreboard queue.
module tb_imem_rom;

    logic        clk;
    logic        clkRun;
    logic        reset;
    logic [5:0]  addr;
    logic [31:0] q;

    logic [31:0] prog [0:46];
    logic [31:0] romModel [0:63];
    logic [31:0] expQ [$];

    int testCount;
    int failCount;

    imem_rom #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .q     (q)
    );

    // Clock can be halted to show the read path does not depend on it.
    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] a, input logic r);
        reset = r;
        addr  = a;
        expQ.push_back(r ? romModel[a] : 32'h0);
    endtask

    task automatic sampleAndCheck(input string tag);
        checkOutput({tag, "_sbDepth"}, 32'(expQ.size()), 32'd1);
        if (expQ.size() != 0) checkOutput(tag, q, expQ.pop_front());
    endtask

    initial begin
        prog = '{
            32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
            32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
            32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
            32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
            32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
            32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
            32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
            32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
            32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
            32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
            32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
            32'h8b1003de, 32'hf81f83d9, 32'hb400001f
        };
        for (int i = 0; i < 64; i++) romModel[i] = (i < 47) ? prog[i] : 32'h0;

        testCount = 0;
        failCount = 0;
        clk       = 1'b0;
        clkRun    = 1'b0;
        reset     = 1'b0;
        addr      = '0;
        #2;

        // Clock stopped: reset gating, release, and address tracking.
        applyStimulus(6'd3, 1'b0);
        #1 sampleAndCheck("rstLowA3");
        applyStimulus(6'd37, 1'b0);
        #1 sampleAndCheck("rstLowA37");
        applyStimulus(6'd3, 1'b1);
        #1 sampleAndCheck("rstRelA3");
        applyStimulus(6'd0, 1'b1);
        #1 sampleAndCheck("stopA0");
        applyStimulus(6'd1, 1'b1);
        #1 sampleAndCheck("stopA1");
        applyStimulus(6'd2, 1'b1);
        #1 sampleAndCheck("stopA2");
        applyStimulus(6'd37, 1'b1);
        #1 sampleAndCheck("stopA37");
        applyStimulus(6'd46, 1'b1);
        #1 sampleAndCheck("stopA46");
        applyStimulus(6'd63, 1'b1);
        #1 sampleAndCheck("stopA63");

        // Clock running: change addr 2 ns after a falling edge, check at the next.
        clkRun = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 64; a++) begin
            #2 applyStimulus(6'(a), 1'b1);
            @(negedge clk);
            sampleAndCheck($sformatf("sweepA%0d", a));
        end

        // Asynchronous assert and release between clock edges.
        #2 applyStimulus(6'd46, 1'b0);
        #1 sampleAndCheck("runRstLow");
        applyStimulus(6'd46, 1'b1);
        #1 sampleAndCheck("runRstRel");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
